mult_share_arb: RTL and testbench
=================================

# mult_share_arb

Round-robin arbiter that shares one combinational `mult_8_8` unsigned 8x8 multiplier among `N_REQ` pixel-datapath requesters, such as filter taps and gain/scale stages. Each requester offers an operand pair with a valid/ready handshake. The block grants one requester per cycle, multiplies the pair through the single `mult_8_8` instance, and registers the 16-bit product together with the winner's ID. The output stage is a one-entry buffer with backpressure, so one arbiter instance replaces N multipliers in resource-constrained image pipelines.

## Interface
Parameters:
- `N_REQ`, default 4, number of requesters; legal range 2..16.
- `ID_W`, default `$clog2(N_REQ)`, requester ID width; minimum 1.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  bit i: requester i presents operands.
- `req_a`  in  8*N_REQ  requester i operand A at `[8*i+:8]`.
- `req_b`  in  8*N_REQ  requester i operand B at `[8*i+:8]`.
- `req_ready`  out  N_REQ  bit i: requester i's pair is accepted this cycle; one-hot or zero.
- `res_valid`  out  1  `res_data` and `res_id` hold a product.
- `res_ready`  in  1  downstream consumes the result this cycle.
- `res_data`  out  16  `req_a[i] * req_b[i]`, unsigned, full width, no truncation.
- `res_id`  out  ID_W  index i of the requester that produced `res_data`.

## Operation
- `out_free = !res_valid || res_ready`.
- Arbitration:
  - The grant is computed combinationally from `req_valid` and the rotating pointer `ptr`.
  - The winner is the first set bit in `req_valid`, searching `ptr`, `ptr+1`, …, `N_REQ-1`, `0`, … (wrapping modulo `N_REQ`).
- Accept:
  - `req_ready[g] = out_free && req_valid[g]` for the winner g; every other bit is 0.
  - A transfer occurs when `req_valid[i] && req_ready[i]`.
- Datapath:
  - The winner's operands are muxed into the single `mult_8_8` instance (`.a`, `.b`, `.c`).
  - On a transfer: `res_data <= c`, `res_id <= g`, `res_valid <= 1`, `ptr <= (g+1) mod N_REQ`.
- Output buffer:
  - If `res_valid && res_ready` and there is no transfer: `res_valid <= 0`.
  - `res_data` and `res_id` keep their previous values when not loaded.
  - While `res_valid && !res_ready`, the output holds stable and all `req_ready` are 0.
- Pointer: unchanged when there is no transfer, including when requests exist but `out_free` is 0.
- Requester protocol: once `req_valid[i]` is raised, it and its operands stay stable until accepted. The block does not check this.
- Fairness: with all requesters continuously valid and `res_ready` held at 1, grants cycle 0,1,…,N_REQ-1,0,… Worst-case wait is N_REQ-1 transfers.

## Timing
- Reset values: `res_valid=0`, `res_data=16'h0000`, `res_id=0`, `ptr=0`.
- `req_ready` is 0 during any cycle in which `rst` is sampled high.
- Reset mid-operation discards the buffered result. No transfer completes in the reset cycle.
- Latency: a transfer in cycle t gives `res_valid=1` with the product in cycle t+1.
- Throughput: one product per cycle while `res_ready` is held high.
- Consume-and-refill: a consume and a transfer in the same cycle load the new product; `res_valid` stays 1 with no bubble.
- Combinational paths:
  - `req_valid` → `req_ready`, through the priority search.
  - `res_ready` → `req_ready`.
  - There is no combinational path from any input to `res_*`.
- Edge products: `8'hFF*8'hFF = 16'hFE01`, and `0*x = 0`; both are exact.

## Structure
- Shared package `mult_share_pkg`:
  - `MULT_W=8`, `PROD_W=16`.
  - Localparam function for ID width, guaranteeing a minimum of 1.
- Sub-module `rr_arbiter` (`N_REQ`):
  - Inputs: `req_valid`, `ptr`, `en`.
  - Outputs: one-hot `grant` and encoded `grant_id`.
  - Purely combinational and reusable by other shared-resource blocks.
- Top level owns:
  - `ptr` and the output register.
  - The operand mux.
  - One `mult_8_8` instance.

## Test plan
1. Reset then single request: `rst` high for 2 cycles, then `req_valid=4'b0100` with `a=8'd12`, `b=8'd13` → `req_ready=4'b0100` in that cycle; next cycle `res_valid=1`, `res_data=16'd156`, `res_id=2`.
2. Fair rotation: all four requesters valid with `res_ready=1` for 8 cycles → `res_id` sequence 0,1,2,3,0,1,2,3; each `res_data` matches that requester's a*b.
3. Backpressure: with `res_valid=1`, hold `res_ready=0` for 3 cycles → `res_data` and `res_id` stable, `req_ready=0`, `ptr` frozen. Raise `res_ready` → the next grant goes to the previously pending winner, with no loss or duplication.
4. Wrap and skip: `ptr=3`, `req_valid=4'b0011` → grant 0, then 1. Then `req_valid=4'b1000` → grant 3, and `ptr` wraps to 0.
5. Extremes plus reset mid-flight: `a=b=8'hFF` → `res_data=16'hFE01`. Assert `rst` while `res_valid=1` → next cycle `res_valid=0`, `res_data=0`, `res_id=0`.
6. Random soak: 1000 cycles of random valid/operands and random `res_ready`. A scoreboard per requester checks every accepted pair yields exactly one result with the correct ID and product, in order.

Source files
------------

// File: rtl/mult_share_pkg.sv
// Shared widths and helpers for the time-shared multiplier arbiter.
package mult_share_pkg;

    localparam int MULT_W = 8;
    localparam int PROD_W = 16;

    // Requester ID width; a single bit is kept even when only one ID is needed.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mult_share_arb_if.sv
// Request/result bundle between pixel-datapath requesters and the shared multiplier.
interface mult_share_arb_if
    import mult_share_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = id_width(N_REQ)
) ();

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [MULT_W*N_REQ-1:0] req_a;
    logic [MULT_W*N_REQ-1:0] req_b;
    logic                    res_valid;
    logic                    res_ready;
    logic [PROD_W-1:0]       res_data;
    logic [ID_W-1:0]         res_id;

    // Requester/consumer side
    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_data, res_id
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_data, res_id
    );

endinterface

// File: rtl/mult_8_8.sv
// Unsigned 8x8 combinational multiplier, full 16-bit product.
module mult_8_8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] c
);

    assign c = 16'(a) * 16'(b);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first valid request at or after ptr, wrapping.
module rr_arbiter
    import mult_share_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]  ptr,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    logic            found;

    // Priority search starting at ptr; grant is suppressed when en is low, id is not.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(N_REQ))
                sum = sum - (ID_W+1)'(N_REQ);
            idx = sum[ID_W-1:0];
            if (!found && req_valid[idx]) begin
                found    = 1'b1;
                grant_id = idx;
            end
        end
        if (en && found)
            grant[grant_id] = 1'b1;
    end

endmodule

// File: rtl/mult_share_arb.sv
// Shares one mult_8_8 among N_REQ requesters with round-robin grant and a
// one-entry registered result buffer with backpressure.
module mult_share_arb
    import mult_share_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  logic           clk,
    input  logic           rst,
    mult_share_arb_if.slave bus
);

    logic [ID_W-1:0]                ptr;
    logic [ID_W-1:0]                grant_id;
    logic [ID_W-1:0]                ptr_nxt;
    logic [N_REQ-1:0]               grant;
    logic                           out_free;
    logic                           xfer;
    logic [N_REQ-1:0][MULT_W-1:0]   a_lane;
    logic [N_REQ-1:0][MULT_W-1:0]   b_lane;
    logic [MULT_W-1:0]              op_a;
    logic [MULT_W-1:0]              op_b;
    logic [PROD_W-1:0]              prod;

    // Buffer can take a new product if empty or being drained this cycle.
    assign out_free = !bus.res_valid || bus.res_ready;

    // Reset masks the grant so nothing is accepted in a reset cycle.
    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req_valid (bus.req_valid),
        .ptr       (ptr),
        .en        (out_free && !rst),
        .grant     (grant),
        .grant_id  (grant_id)
    );

    assign bus.req_ready = grant;
    assign xfer          = |grant;

    // Operand mux in front of the single multiplier.
    assign a_lane = bus.req_a;
    assign b_lane = bus.req_b;
    assign op_a   = a_lane[grant_id];
    assign op_b   = b_lane[grant_id];

    mult_8_8 u_mult (
        .a (op_a),
        .b (op_b),
        .c (prod)
    );

    assign ptr_nxt = (grant_id == ID_W'(N_REQ-1)) ? '0 : grant_id + ID_W'(1);

    // Result buffer and rotating pointer; loaded on transfer, cleared on drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_id    <= '0;
            ptr           <= '0;
        end else if (xfer) begin
            bus.res_valid <= 1'b1;
            bus.res_data  <= prod;
            bus.res_id    <= grant_id;
            ptr           <= ptr_nxt;
        end else if (bus.res_valid && bus.res_ready) begin
            bus.res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mult_share_arb.sv
// Bench for mult_share_arb: directed scenarios plus random soak, with a
// queue-based scoreboard and a separate result monitor.
module tb_mult_share_arb;
    import mult_share_pkg::*;

    localparam int N  = 4;
    localparam int IW = id_width(N);

    typedef struct {
        logic [IW-1:0] id;
        logic [15:0]   data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mult_share_arb_if #(.N_REQ(N)) bus ();

    mult_share_arb #(.N_REQ(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic        pend[N];
    logic [7:0]  ca[N];
    logic [7:0]  cb[N];
    int          m_ptr = 0;
    bit          m_occ = 1'b0;
    logic [N-1:0] seen_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: round-robin from the model pointer over pending requesters.
    task automatic eval();
        logic [N-1:0] eg;
        int g;
        eg = '0;
        g  = -1;
        if (!rst && (!m_occ || bus.res_ready))
            for (int k = 0; k < N; k++)
                if (g < 0 && pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        if (g >= 0) eg[g] = 1'b1;
        seen_rdy = bus.req_ready;
        chk("req_ready", 32'(bus.req_ready), 32'(eg));
        chk("res_valid", 32'(bus.res_valid), 32'(m_occ));
        if (rst) begin
            m_occ = 1'b0;
            m_ptr = 0;
            exp_q.delete();
        end else begin
            for (int i = 0; i < N; i++)
                if (pend[i] && bus.req_ready[i]) begin
                    exp_q.push_back('{id: IW'(i), data: 16'(ca[i]) * 16'(cb[i])});
                    pend[i] = 1'b0;
                end
            if (g >= 0) begin
                m_ptr = (g + 1) % N;
                m_occ = 1'b1;
            end else if (m_occ && bus.res_ready) begin
                m_occ = 1'b0;
            end
        end
    endtask

    // One clock: drive after posedge, evaluate at negedge, return just after next posedge.
    task automatic step(input bit r, input bit rr);
        rst           = r;
        bus.res_ready = rr;
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]     = pend[i];
            bus.req_a[8*i +: 8]  = ca[i];
            bus.req_b[8*i +: 8]  = cb[i];
        end
        @(negedge clk);
        eval();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pick();
        int s;
        s = int'($urandom_range(0, 7));
        if (s == 0) return 8'hFF;
        if (s == 1) return 8'h00;
        return 8'($urandom);
    endfunction

    function automatic bit any_pend();
        bit r;
        r = 1'b0;
        for (int i = 0; i < N; i++) if (pend[i]) r = 1'b1;
        return r;
    endfunction

    // Monitor: every consumed result must match the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.res_valid && bus.res_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_result: got id %0d data %0h with no pending expectation",
                             bus.res_id, bus.res_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_id", 32'(bus.res_id), 32'(e.id));
                    chk("res_data", 32'(bus.res_data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            ca[i]   = '0;
            cb[i]   = '0;
        end
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset for two cycles
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("rst_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_data", 32'(bus.res_data), 32'd0);
        chk("rst_id", 32'(bus.res_id), 32'd0);

        // Single request on lane 2
        pend[2] = 1'b1; ca[2] = 8'd12; cb[2] = 8'd13;
        step(1'b0, 1'b1);
        chk("t1_ready", 32'(seen_rdy), 32'h4);
        chk("t1_valid", 32'(bus.res_valid), 32'd1);
        chk("t1_data", 32'(bus.res_data), 32'd156);
        chk("t1_id", 32'(bus.res_id), 32'd2);

        // Pointer at 3: wrap to 0, then 1, then lone request 3 wraps pointer to 0
        pend[0] = 1'b1; ca[0] = 8'd7; cb[0] = 8'd9;
        pend[1] = 1'b1; ca[1] = 8'd0; cb[1] = 8'd200;
        step(1'b0, 1'b1);
        chk("t4_g0", 32'(seen_rdy), 32'h1);
        step(1'b0, 1'b1);
        chk("t4_g1", 32'(seen_rdy), 32'h2);
        pend[3] = 1'b1; ca[3] = 8'hA5; cb[3] = 8'd3;
        step(1'b0, 1'b1);
        chk("t4_g3", 32'(seen_rdy), 32'h8);

        // Fair rotation with everyone valid
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i]) begin
                    pend[i] = 1'b1; ca[i] = pick(); cb[i] = pick();
                end
            step(1'b0, 1'b1);
            chk("t2_rot", 32'(seen_rdy), 32'd1 << (c % 4));
        end

        // Backpressure: output frozen, no grants
        for (int i = 0; i < N; i++)
            if (!pend[i]) begin
                pend[i] = 1'b1; ca[i] = pick(); cb[i] = pick();
            end
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b0);
            chk("t3_ready", 32'(seen_rdy), 32'd0);
            chk("t3_id", 32'(bus.res_id), 32'd3);
            if (exp_q.size() != 0)
                chk("t3_data", 32'(bus.res_data), 32'(exp_q[0].data));
        end
        step(1'b0, 1'b1);
        chk("t3_resume", 32'(seen_rdy), 32'h1);
        for (int c = 0; c < 3; c++) step(1'b0, 1'b1);

        // Zero and full-scale products
        pend[1] = 1'b1; ca[1] = 8'h00; cb[1] = 8'h5A;
        pend[2] = 1'b1; ca[2] = 8'hFF; cb[2] = 8'hFF;
        step(1'b0, 1'b1);
        chk("t5_g1", 32'(seen_rdy), 32'h2);
        chk("t5_zero", 32'(bus.res_data), 32'd0);
        step(1'b0, 1'b1);
        chk("t5_max", 32'(bus.res_data), 32'hFE01);
        chk("t5_id", 32'(bus.res_id), 32'd2);

        // Reset while a result is buffered
        pend[0] = 1'b1; ca[0] = 8'd3; cb[0] = 8'd4;
        step(1'b1, 1'b0);
        chk("t5_rst_ready", 32'(seen_rdy), 32'd0);
        chk("t5_rst_valid", 32'(bus.res_valid), 32'd0);
        chk("t5_rst_data", 32'(bus.res_data), 32'd0);
        chk("t5_rst_id", 32'(bus.res_id), 32'd0);
        step(1'b0, 1'b1);

        // Random soak
        for (int c = 0; c < 1000; c++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1; ca[i] = pick(); cb[i] = pick();
                end
            step($urandom_range(0, 249) == 0, $urandom_range(0, 3) != 0);
        end

        // Drain everything still pending
        guard = 0;
        while ((any_pend() || exp_q.size() != 0) && guard < 50) begin
            step(1'b0, 1'b1);
            guard++;
        end
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
        chk("drain_pend", 32'(any_pend()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
